// File: rtl/regfile_scoreboard.sv
// Purpose: 32 x XLEN integer register file with a per-register pending-writer scoreboard for ID hazard stalls.
// Latency: reads are combinational; writes and counter updates take effect after the rising clk edge.
// Backpressure: there is none internally. stall_ID is advisory, and the ID stage must gate issue_valid with it.
//
// Optional feature: define REGFILE_BYPASS_EN to forward write-back data to the read ports in the same cycle.
// The hazard check then also ignores the writer that retires this cycle.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   rs1_ID/rs2_ID         source addresses; rs1_used/rs2_used qualify them for the stall check
//   issue_valid/issue_rd/issue_reg_write   instruction leaving ID (counter increment)
//   kill_valid/kill_rd    squashed in-flight writer (counter decrement)
//   rd_WB/reg_write_WB/write_data_WB        write-back port (write + counter decrement)
//   rs1_data/rs2_data     combinational read data
//   stall_ID              combinational RAW hazard
//   busy_mask             bit i set while counter i is non-zero
//   sb_error              sticky counter over/underflow flag; cleared only by reset
module regfile_scoreboard #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_ID,
  input  logic [4:0]      rs2_ID,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            issue_reg_write,
  input  logic            kill_valid,
  input  logic [4:0]      kill_rd,
  input  logic [4:0]      rd_WB,
  input  logic            reg_write_WB,
  input  logic [XLEN-1:0] write_data_WB,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            stall_ID,
  output logic [31:0]     busy_mask,
  output logic            sb_error
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [XLEN-1:0]  regs    [32];
  logic [CNT_W-1:0] cnt     [32];
  logic [CNT_W-1:0] cnt_nxt [32];
  logic             err_nxt;

  // Net counter update per register. All coinciding events are summed before clamping,
  // so issue and retire in the same cycle cancel out without flagging an error.
  always_comb begin
    int sum;
    sum     = 0;
    err_nxt = 1'b0;
    for (int r = 0; r < 32; r++) begin
      cnt_nxt[r] = '0;
      if (r != 0) begin
        sum = int'(cnt[r])
            + int'(issue_valid && issue_reg_write && (issue_rd == 5'(r)))
            - int'(reg_write_WB && (rd_WB == 5'(r)))
            - int'(kill_valid && (kill_rd == 5'(r)));
        if (sum > CNT_MAX) begin
          cnt_nxt[r] = CNT_W'(CNT_MAX);
          err_nxt    = 1'b1;
        end else if (sum < 0) begin
          cnt_nxt[r] = '0;
          err_nxt    = 1'b1;
        end else begin
          cnt_nxt[r] = CNT_W'(sum);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin
        cnt[r] <= '0;
      end
      sb_error <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      sb_error <= sb_error | err_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin
        regs[r] <= '0;
      end
    end else if (reg_write_WB && (rd_WB != 5'd0)) begin
      regs[rd_WB] <= write_data_WB;
    end
  end

  // Hazard uses the pre-update counters, so an issuing instruction never sees its own rd.
  function automatic logic hz(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    int pend;
    // The writer retiring this cycle is forwarded, and a killed writer will never arrive.
    pend = int'(cnt[a])
         - int'(reg_write_WB && (rd_WB == a))
         - int'(kill_valid && (kill_rd == a));
    return (a != 5'd0) && (pend > 0);
`else
    return (a != 5'd0) && (cnt[a] != '0);
`endif
  endfunction

  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a);
    if (a == 5'd0) begin
      return '0;
    end
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed while in reset so the read ports stay at zero.
    if (reset && reg_write_WB && (rd_WB == a)) begin
      return write_data_WB;
    end
`endif
    return regs[a];
  endfunction

  always_comb begin
    rs1_data = rd_port(rs1_ID);
    rs2_data = rd_port(rs2_ID);
    stall_ID = (rs1_used && hz(rs1_ID)) || (rs2_used && hz(rs2_ID));
    for (int r = 0; r < 32; r++) begin
      busy_mask[r] = (cnt[r] != '0);
    end
  end

endmodule
